viterbi_decoder: RTL and testbench
==================================

# viterbi_decoder

Parametrised hard-decision Viterbi decoder for rate-1/2 convolutional codes. Constraint length, generator polynomials, traceback depth and metric width are all parameters. Each accepted 2-bit symbol passes through a full add-compare-select (ACS) step. Survivors are stored in a circular memory, and decoded bits are produced by a sliding-window traceback, with a zero-tail flush on the last symbol of a frame. Valid/ready handshakes on both sides let it sit between the channel-symbol source and the frame sink in the encoder/decoder system.

## Interface
- `K`, default 3: constraint length, legal range 3..7. Number of states S = 2^(K-1).
- `G0`, default 3'b111: generator polynomial for code bit c0, K bits wide.
- `G1`, default 3'b101: generator polynomial for code bit c1, K bits wide.
- `TB_DEPTH`, default 15: traceback window in symbols, legal range ≥ 2*K.
- `PM_W`, default 8: path-metric width in bits.
- `clk`, input, 1 bit: the only clock. All state updates on its rising edge.
- `rst_n`, input, 1 bit: asynchronous, active-low reset.
- `in_valid`, input, 1 bit: `in_sym` and `in_last` are valid.
- `in_ready`, output, 1 bit: the decoder can accept a symbol.
- `in_sym`, input, 2 bits: received symbol {c0, c1}.
- `in_last`, input, 1 bit: final symbol of the frame; the frame is zero-tailed.
- `out_valid`, output, 1 bit: `out_bit` is valid.
- `out_ready`, input, 1 bit: the sink accepts `out_bit`.
- `out_bit`, output, 1 bit: decoded information bit, oldest first.
- `out_last`, output, 1 bit: marks the final decoded bit of the frame.

## Operation
- **Encoder model.**
  - State s is K-1 bits wide. For input bit u, form reg = {u, s}.
  - c0 = ^(reg & G0), c1 = ^(reg & G1).
  - Next state = {u, s[K-2:1]}.
- **Branch metric.** Hamming distance between `in_sym` and the expected {c0, c1}, range 0..2.
- **ACS.**
  - The predecessors of state s are {s[K-3:0], b} for b = 0 and b = 1.
  - New metric = min over b of (old_pm + branch metric).
  - Decision bit = the winning b. On a tie, b = 0.
  - All S states update in the single ACS cycle.
- **Normalisation.** Every new metric has the previous step's minimum metric subtracted from it. All metric arithmetic saturates at 2^PM_W - 1.
- **Metric initialisation.** At reset and after each frame flush: pm[0] = 0, all other pm[s] = 2^(PM_W-1).
- **Survivor memory.**
  - TB_DEPTH columns of S decision bits, written circularly at `wr_ptr`. `wr_ptr` wraps from TB_DEPTH-1 to 0.
  - `fill` counts stored columns and saturates at TB_DEPTH.
- **Traceback.**
  - Each step reads decision d for the current state s.
  - Decoded bit = s[K-2]; previous state = {s[K-3:0], d}.
  - Decoded bits are written into a TB_DEPTH-bit buffer, so emission order is oldest first.
- **FSM states.** ACS, TRACE, EMIT.
  - **ACS:** `in_ready` = 1. On a handshake, run ACS, write a column, update `fill`.
    - If `in_last` = 1: go to TRACE in flush mode, starting from state 0 with length L = `fill`.
    - Else if `fill` == TB_DEPTH: go to TRACE in normal mode, starting from the lowest-index minimum-metric state with L = TB_DEPTH.
    - Otherwise: stay in ACS.
  - **TRACE:** one step per cycle for L cycles, then go to EMIT.
  - **EMIT, normal mode:** emit one bit, the oldest in the window, with `out_last` = 0.
  - **EMIT, flush mode:** emit all L bits oldest first, with `out_last` on the L-th bit. Then reinitialise the metrics, clear `fill` and `wr_ptr`, and return to ACS.
- **Bit accounting.** A frame of N symbols yields exactly N output bits.
- **Backpressure.** `out_bit`, `out_valid` and `out_last` hold stable until `out_ready`. `in_ready` stays 0 throughout TRACE and EMIT.

## Timing
- **Reset values.**
  - Outputs: `in_ready` = 0 while `rst_n` is low, and 1 in the first cycle after deassertion. `out_valid` = 0, `out_bit` = 0, `out_last` = 0.
  - Internal: FSM = ACS, `fill` = 0, `wr_ptr` = 0, metrics initialised.
- **Latency.** A symbol accepted at cycle t gives TRACE over t+1..t+L and `out_valid` = 1 at t+L+1.
- **Throughput.**
  - During the fill phase: 1 symbol per cycle.
  - Steady state: 1 symbol per TB_DEPTH+2 cycles with no backpressure.
- **Output beats.** Consecutive flush output bits come one per cycle while `out_ready` = 1. `in_ready` returns one cycle after the final output handshake.
- **Reset mid-frame.** The frame is aborted and all state returns to reset values. No partial `out_last` is produced.
- **Single-symbol frame.** `in_last` on the first symbol gives L = 1: one output bit with `out_last` = 1.

## Structure
- **Package `viterbi_pkg`.**
  - FSM state enum.
  - Function `conv_out(reg, G0, G1)` returning {c0, c1}.
  - Function `hamming2`.
  - Metric saturation constant.
- **Sub-module `viterbi_acs_unit`.** One instance per state, generated S times. It takes two predecessor metrics and two branch metrics, and returns the new metric and the decision bit.
- **Top level.** FSM, survivor memory, traceback and output buffer.

## Test plan
- **Clean frame.** K=3, G=(7,5), TB_DEPTH=15. Symbols 11,10,00,01,01,11 with `in_last` on the 6th → out 1,0,1,1,0,0, with `out_last` on the 6th bit.
- **Single error.** Same frame with the 3rd symbol changed to 10 → identical output 1,0,1,1,0,0.
- **Long stream.** 100 random bits plus 2 tail zeros, encoded, with no errors.
  - The first `out_valid` arrives after the 15th symbol's traceback, 16 cycles after its acceptance.
  - Output equals the input bits followed by the two tail zeros; 102 bits total.
  - `out_last` is asserted only on bit 102.
- **Backpressure.** Hold `out_ready` = 0 for 5 cycles during the flush → `out_bit` is stable, `in_ready` = 0, and no bit is lost or duplicated.
- **Reset mid-frame.** Pull `rst_n` low during TRACE → `out_valid` = 0 immediately. A following clean frame decodes correctly.
- **K=5, G=(23,35) octal, TB_DEPTH=30.** Random frame with 3 spaced errors → error-free output; `fill` saturates at 30 and `wr_ptr` wraps.

Source files
------------

// File: rtl/viterbi_pkg.sv
// Shared types and helpers for the hard-decision rate-1/2 Viterbi decoder.
// Widths are sized for the largest supported constraint length.
package viterbi_pkg;

   typedef enum logic [1:0] {StAcs, StTrace, StEmit} state_e;

   localparam int unsigned MaxK = 7;

   function automatic logic [1:0] conv_out(input logic [MaxK-1:0] r,
                                           input logic [MaxK-1:0] g0,
                                           input logic [MaxK-1:0] g1);
      return {^(r & g0), ^(r & g1)};
   endfunction

   function automatic logic [1:0] hamming2(input logic [1:0] a, input logic [1:0] b);
      logic [1:0] x;
      x = a ^ b;
      return {1'b0, x[1]} + {1'b0, x[0]};
   endfunction

   // Saturation ceiling for a path metric of the given width.
   function automatic int unsigned pm_sat(input int unsigned w);
      return (1 << w) - 1;
   endfunction

endpackage

// File: rtl/viterbi_acs_unit.sv
// Add-compare-select for one trellis state with saturating adds and
// subtraction of the previous step's minimum metric.
module viterbi_acs_unit
   import viterbi_pkg::*;
#(
   parameter int unsigned PM_W = 8
) (
   input  logic [PM_W-1:0] i_pm0,
   input  logic [PM_W-1:0] i_pm1,
   input  logic [1:0]      i_bm0,
   input  logic [1:0]      i_bm1,
   input  logic [PM_W-1:0] i_pm_min,
   output logic [PM_W-1:0] o_pm,
   output logic            o_dec
);

   localparam logic [PM_W:0] PmMax = (PM_W+1)'(pm_sat(PM_W));

   logic [PM_W:0]   w_sum0;
   logic [PM_W:0]   w_sum1;
   logic [PM_W:0]   w_sat0;
   logic [PM_W:0]   w_sat1;
   logic [PM_W-1:0] w_best;

   always_comb begin
      w_sum0 = {1'b0, i_pm0} + {{(PM_W-1){1'b0}}, i_bm0};
      w_sum1 = {1'b0, i_pm1} + {{(PM_W-1){1'b0}}, i_bm1};
      w_sat0 = (w_sum0 > PmMax) ? PmMax : w_sum0;
      w_sat1 = (w_sum1 > PmMax) ? PmMax : w_sum1;
      // Ties resolve to the b = 0 predecessor.
      o_dec  = (w_sat1 < w_sat0);
      w_best = o_dec ? w_sat1[PM_W-1:0] : w_sat0[PM_W-1:0];
      o_pm   = w_best - i_pm_min;
   end

endmodule

// File: rtl/viterbi_decoder.sv
// Hard-decision Viterbi decoder: ACS over all states per symbol, circular survivor
// memory and sliding-window traceback with a zero-tail flush at frame end.
module viterbi_decoder
   import viterbi_pkg::*;
#(
   parameter int unsigned  K        = 3,
   parameter logic [K-1:0] G0       = 3'b111,
   parameter logic [K-1:0] G1       = 3'b101,
   parameter int unsigned  TB_DEPTH = 15,
   parameter int unsigned  PM_W     = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [1:0] in_sym,
   input  logic       in_last,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       out_bit,
   output logic       out_last
);

   localparam int unsigned S  = 1 << (K - 1);
   localparam int unsigned SW = K - 1;
   localparam int unsigned PW = $clog2(TB_DEPTH);
   localparam int unsigned CW = $clog2(TB_DEPTH + 1);
   localparam logic [PM_W-1:0] PmInit = {1'b1, {(PM_W-1){1'b0}}};

   state_e              r_state;
   logic                r_in_ready;
   logic                r_out_valid;
   logic                r_out_bit;
   logic                r_out_last;
   logic                r_flush;
   logic [PM_W-1:0]     r_pm [S];
   logic [PM_W-1:0]     r_pm_min;
   logic [S-1:0]        r_surv [TB_DEPTH];
   logic [PW-1:0]       r_wr_ptr;
   logic [PW-1:0]       r_rd_ptr;
   logic [CW-1:0]       r_fill;
   logic [CW-1:0]       r_len;
   logic [CW-1:0]       r_step;
   logic [CW-1:0]       r_emit_idx;
   logic [SW-1:0]       r_tb_state;
   logic [TB_DEPTH-1:0] r_dec_buf;

   logic [PM_W-1:0]     w_pm_new [S];
   logic [S-1:0]        w_dec;
   logic [PM_W-1:0]     w_new_min;
   logic [SW-1:0]       w_new_min_idx;
   logic                w_acc;
   logic [CW-1:0]       w_fill_next;
   logic [PW-1:0]       w_wr_next;
   logic [PW-1:0]       w_rd_prev;
   logic                w_tb_d;
   logic                w_tb_bit;
   logic [SW-1:0]       w_tb_prev;

   // Predecessors of state s are {s[K-3:0], b}; the input bit on that branch is s[K-2].
   for (genvar gs = 0; gs < S; gs++) begin : g_acs
      localparam int unsigned P0 = (gs << 1) % S;
      localparam int unsigned P1 = P0 + 1;
      localparam int unsigned U  = gs >> (K - 2);
      localparam logic [MaxK-1:0] R0 = MaxK'((U << (K - 1)) | P0);
      localparam logic [MaxK-1:0] R1 = MaxK'((U << (K - 1)) | P1);

      logic [1:0] w_bm0;
      logic [1:0] w_bm1;

      assign w_bm0 = hamming2(in_sym, conv_out(R0, MaxK'(G0), MaxK'(G1)));
      assign w_bm1 = hamming2(in_sym, conv_out(R1, MaxK'(G0), MaxK'(G1)));

      viterbi_acs_unit #(.PM_W(PM_W)) u_acs (
         .i_pm0    (r_pm[P0]),
         .i_pm1    (r_pm[P1]),
         .i_bm0    (w_bm0),
         .i_bm1    (w_bm1),
         .i_pm_min (r_pm_min),
         .o_pm     (w_pm_new[gs]),
         .o_dec    (w_dec[gs])
      );
   end

   always_comb begin
      w_new_min     = w_pm_new[0];
      w_new_min_idx = '0;
      for (int i = 1; i < S; i++) begin
         if (w_pm_new[i] < w_new_min) begin
            w_new_min     = w_pm_new[i];
            w_new_min_idx = SW'(i);
         end
      end
   end

   assign w_acc       = in_valid && r_in_ready;
   assign w_fill_next = (r_fill == CW'(TB_DEPTH)) ? r_fill : r_fill + CW'(1);
   assign w_wr_next   = (r_wr_ptr == PW'(TB_DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
   assign w_rd_prev   = (r_rd_ptr == '0) ? PW'(TB_DEPTH - 1) : r_rd_ptr - PW'(1);
   assign w_tb_d      = r_surv[r_rd_ptr][r_tb_state];
   assign w_tb_bit    = r_tb_state[SW-1];
   assign w_tb_prev   = {r_tb_state[SW-2:0], w_tb_d};

   always_ff @(posedge clk) begin
      if (w_acc) r_surv[r_wr_ptr] <= w_dec;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= StAcs;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_bit   <= 1'b0;
         r_out_last  <= 1'b0;
         r_flush     <= 1'b0;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_fill      <= '0;
         r_len       <= '0;
         r_step      <= '0;
         r_emit_idx  <= '0;
         r_tb_state  <= '0;
         r_dec_buf   <= '0;
         r_pm_min    <= '0;
         for (int i = 0; i < S; i++) r_pm[i] <= (i == 0) ? '0 : PmInit;
      end else begin
         unique case (r_state)
            StAcs: begin
               r_in_ready <= 1'b1;
               if (w_acc) begin
                  for (int i = 0; i < S; i++) r_pm[i] <= w_pm_new[i];
                  r_pm_min <= w_new_min;
                  r_wr_ptr <= w_wr_next;
                  r_fill   <= w_fill_next;
                  r_rd_ptr <= r_wr_ptr;
                  r_step   <= '0;
                  if (in_last) begin
                     r_flush    <= 1'b1;
                     r_tb_state <= '0;
                     r_len      <= w_fill_next;
                     r_in_ready <= 1'b0;
                     r_state    <= StTrace;
                  end else if (w_fill_next == CW'(TB_DEPTH)) begin
                     r_flush    <= 1'b0;
                     r_tb_state <= w_new_min_idx;
                     r_len      <= CW'(TB_DEPTH);
                     r_in_ready <= 1'b0;
                     r_state    <= StTrace;
                  end
               end
            end
            StTrace: begin
               // Step 0 yields the newest bit, so buffer index grows with age.
               r_dec_buf[r_step] <= w_tb_bit;
               r_tb_state        <= w_tb_prev;
               r_rd_ptr          <= w_rd_prev;
               r_step            <= r_step + CW'(1);
               if (r_step == r_len - CW'(1)) begin
                  r_state     <= StEmit;
                  r_out_valid <= 1'b1;
                  r_out_bit   <= w_tb_bit;
                  r_out_last  <= r_flush && (r_len == CW'(1));
                  r_emit_idx  <= r_len - CW'(1);
               end
            end
            StEmit: begin
               if (out_ready) begin
                  if (r_flush && (r_emit_idx != '0)) begin
                     r_emit_idx <= r_emit_idx - CW'(1);
                     r_out_bit  <= r_dec_buf[r_emit_idx - CW'(1)];
                     r_out_last <= (r_emit_idx == CW'(1));
                  end else begin
                     r_out_valid <= 1'b0;
                     r_out_last  <= 1'b0;
                     r_in_ready  <= 1'b1;
                     r_state     <= StAcs;
                     if (r_flush) begin
                        r_flush  <= 1'b0;
                        r_fill   <= '0;
                        r_wr_ptr <= '0;
                        r_pm_min <= '0;
                        for (int i = 0; i < S; i++) r_pm[i] <= (i == 0) ? '0 : PmInit;
                     end
                  end
               end
            end
            default: r_state <= StAcs;
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_bit   = r_out_bit;
   assign out_last  = r_out_last;

endmodule

// File: tb/tb_viterbi_decoder.sv
// Directed bench for viterbi_decoder: a K=3 (7,5) instance and a K=5 (23,35) instance
// share one stimulus path selected by sel.
module tb_viterbi_decoder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n = 1'b1;
   logic       sel = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_last = 1'b0;
   logic       out_ready = 1'b1;
   logic [1:0] in_sym = 2'b00;

   logic a_in_ready, a_out_valid, a_out_bit, a_out_last;
   logic b_in_ready, b_out_valid, b_out_bit, b_out_last;
   logic in_ready, out_valid, out_bit, out_last;

   assign in_ready  = sel ? b_in_ready  : a_in_ready;
   assign out_valid = sel ? b_out_valid : a_out_valid;
   assign out_bit   = sel ? b_out_bit   : a_out_bit;
   assign out_last  = sel ? b_out_last  : a_out_last;

   viterbi_decoder dut_k3 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid & ~sel),
      .in_ready  (a_in_ready),
      .in_sym    (in_sym),
      .in_last   (in_last),
      .out_valid (a_out_valid),
      .out_ready (out_ready),
      .out_bit   (a_out_bit),
      .out_last  (a_out_last)
   );

   viterbi_decoder #(
      .K        (5),
      .G0       (5'o23),
      .G1       (5'o35),
      .TB_DEPTH (30),
      .PM_W     (8)
   ) dut_k5 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid & sel),
      .in_ready  (b_in_ready),
      .in_sym    (in_sym),
      .in_last   (in_last),
      .out_valid (b_out_valid),
      .out_ready (out_ready),
      .out_bit   (b_out_bit),
      .out_last  (b_out_last)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_total = 0;
   int n_bad   = 0;

   logic [1:0] tx_sym  [256];
   logic       exp_bit [256];
   logic       rx_bit  [256];
   int         acc_cyc [256];
   int         rx_n, n_last, last_pos, first_cyc;
   logic [63:0] rx_word;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic encode(input int n, input int k, input int g0, input int g1);
      int st = 0;
      int r;
      for (int i = 0; i < n; i++) begin
         r = (int'(exp_bit[i]) << (k - 1)) | st;
         tx_sym[i] = {1'($countones(r & g0) & 1), 1'($countones(r & g1) & 1)};
         st = (int'(exp_bit[i]) << (k - 2)) | (st >> 1);
      end
   endtask

   // Starts and ends on a negedge; in_ready sampled there decides the next posedge.
   task automatic send_syms(input int n, input int probe);
      int wait_c;
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1;
         in_sym   = tx_sym[i];
         in_last  = (i == n - 1);
         wait_c   = 0;
         while (!in_ready && wait_c < 200) begin
            @(negedge clk);
            wait_c++;
         end
         if (!in_ready) begin
            check_eq("in_ready_timeout", 64'(in_ready), 64'd1);
            break;
         end
         acc_cyc[i] = cyc;
         @(negedge clk);
         if (i == probe) begin
            check_eq("k5_fill_sat", 64'(dut_k5.r_fill), 64'd30);
            check_eq("k5_wr_ptr_wrap", 64'(dut_k5.r_wr_ptr), 64'((probe + 1) % 30));
         end
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic collect(input int n_exp, input int bp_at);
      int   idle = 0;
      logic held;
      rx_n = 0; n_last = 0; last_pos = -1; first_cyc = -1;
      out_ready = 1'b1;
      while (rx_n < n_exp && idle < 3000) begin
         if (out_valid) begin
            if (first_cyc < 0) first_cyc = cyc;
            if (rx_n == bp_at) begin
               held = out_bit;
               out_ready = 1'b0;
               repeat (5) begin
                  @(negedge clk);
                  check_eq("bp_valid", 64'(out_valid), 64'd1);
                  check_eq("bp_bit_stable", 64'(out_bit), 64'(held));
                  check_eq("bp_in_ready", 64'(in_ready), 64'd0);
               end
               out_ready = 1'b1;
               bp_at = -1;
            end
            rx_bit[rx_n] = out_bit;
            if (out_last) begin
               n_last++;
               last_pos = rx_n;
            end
            rx_n++;
         end else begin
            idle++;
         end
         @(negedge clk);
      end
      out_ready = 1'b1;
   endtask

   task automatic run_frame(input string tag, input int n, input int bp_at, input int probe);
      int errs = 0;
      fork
         send_syms(n, probe);
         collect(n, bp_at);
      join
      rx_word = '0;
      for (int i = 0; i < rx_n; i++) begin
         if (rx_bit[i] !== exp_bit[i]) errs++;
         if (i < 64) rx_word = {rx_word[62:0], rx_bit[i]};
      end
      check_eq({tag, "_count"}, 64'(rx_n), 64'(n));
      check_eq({tag, "_bit_errs"}, 64'(errs), 64'd0);
      check_eq({tag, "_n_last"}, 64'(n_last), 64'd1);
      check_eq({tag, "_last_pos"}, 64'(last_pos), 64'(n - 1));
      check_eq({tag, "_in_ready_back"}, 64'(in_ready), 64'd1);
   endtask

   task automatic load_clean();
      tx_sym[0] = 2'b11; tx_sym[1] = 2'b10; tx_sym[2] = 2'b00;
      tx_sym[3] = 2'b01; tx_sym[4] = 2'b01; tx_sym[5] = 2'b11;
      exp_bit[0] = 1; exp_bit[1] = 0; exp_bit[2] = 1;
      exp_bit[3] = 1; exp_bit[4] = 0; exp_bit[5] = 0;
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_in_ready", 64'(in_ready), 64'd0);
      check_eq("rst_out_valid", 64'(out_valid), 64'd0);
      check_eq("rst_out_bit", 64'(out_bit), 64'd0);
      check_eq("rst_out_last", 64'(out_last), 64'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_eq("in_ready_after_rst", 64'(in_ready), 64'd1);
      @(negedge clk);

      load_clean();
      run_frame("clean", 6, -1, -1);
      check_eq("clean_bits", rx_word, 64'b101100);
      check_eq("clean_latency", 64'(first_cyc - acc_cyc[5]), 64'd7);

      load_clean();
      tx_sym[2] = 2'b10;
      run_frame("one_err", 6, -1, -1);
      check_eq("one_err_bits", rx_word, 64'b101100);

      tx_sym[0] = 2'b11;
      exp_bit[0] = 1'b0;
      run_frame("single", 1, -1, -1);
      check_eq("single_bit", rx_word, 64'd0);
      check_eq("single_latency", 64'(first_cyc - acc_cyc[0]), 64'd2);

      load_clean();
      run_frame("backpr", 6, 3, -1);
      check_eq("backpr_bits", rx_word, 64'b101100);

      for (int i = 0; i < 100; i++) exp_bit[i] = 1'($urandom_range(0, 1));
      exp_bit[100] = 1'b0;
      exp_bit[101] = 1'b0;
      encode(102, 3, 'o7, 'o5);
      run_frame("long", 102, -1, -1);
      check_eq("long_latency", 64'(first_cyc - acc_cyc[14]), 64'd16);

      load_clean();
      send_syms(6, -1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_eq("midrst_out_valid", 64'(out_valid), 64'd0);
      check_eq("midrst_out_last", 64'(out_last), 64'd0);
      check_eq("midrst_in_ready", 64'(in_ready), 64'd0);
      repeat (2) @(negedge clk);
      check_eq("midrst_held_valid", 64'(out_valid), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("midrst_ready_back", 64'(in_ready), 64'd1);
      run_frame("after_rst", 6, -1, -1);
      check_eq("after_rst_bits", rx_word, 64'b101100);

      sel = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 50; i++) exp_bit[i] = 1'($urandom_range(0, 1));
      for (int i = 50; i < 54; i++) exp_bit[i] = 1'b0;
      encode(54, 5, 'o23, 'o35);
      tx_sym[10] = tx_sym[10] ^ 2'b01;
      tx_sym[25] = tx_sym[25] ^ 2'b10;
      tx_sym[40] = tx_sym[40] ^ 2'b01;
      run_frame("k5", 54, -1, 40);
      check_eq("k5_latency", 64'(first_cyc - acc_cyc[29]), 64'd31);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
